// File: rtl/nes_joy_pkg.sv
// Shared button encoding for the NES joypad path (USB decoder and serializer).
// The helper gives a single definition of the "no opposite d-pad" rule.
package nes_joy_pkg;

    localparam int BTN_W      = 8;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef logic [BTN_W-1:0] btn_vec_t;

    // A real d-pad cannot report both directions of an axis; some games crash if it does.
    function automatic btn_vec_t filter_opposite(input btn_vec_t v);
        btn_vec_t r;
        r = v;
        if (v[BTN_UP] && v[BTN_DOWN]) begin
            r[BTN_UP]   = 1'b0;
            r[BTN_DOWN] = 1'b0;
        end
        if (v[BTN_LEFT] && v[BTN_RIGHT]) begin
            r[BTN_LEFT]  = 1'b0;
            r[BTN_RIGHT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nes_joypad_serializer_port.sv
// One 4021-style controller port: button synchroniser, skew-free snapshot,
// d-pad filter, strobe/shift register and read falling-edge detection.
module nes_joypad_port
    import nes_joy_pkg::*;
#(
    parameter int C_SYNC_STAGES     = 2,
    parameter int C_FILTER_OPPOSITE = 1,
    parameter bit C_FILL_BIT        = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [BTN_W-1:0] i_btn,
    input  logic             i_strobe,
    input  logic             i_rd,
    output logic             o_data
);

    btn_vec_t sync_q [C_SYNC_STAGES];
    btn_vec_t sync_d [C_SYNC_STAGES];
    btn_vec_t snap_q, snap_d;
    btn_vec_t filt;
    btn_vec_t sh_q, sh_d;
    logic     rd_q, rd_d;
    logic     data_q, data_d;
    logic     rd_fall;

    always_comb begin
        sync_d[0] = i_btn;
        for (int i = 1; i < C_SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // The last stage is only trusted when the stage behind it agrees, so a
    // vector whose bits cross the clock boundary on different edges is never captured.
    always_comb begin
        snap_d = snap_q;
        if (sync_q[C_SYNC_STAGES-1] == sync_q[C_SYNC_STAGES-2]) begin
            snap_d = sync_q[C_SYNC_STAGES-1];
        end
    end

    always_comb begin
        filt = snap_q;
        if (C_FILTER_OPPOSITE != 0) begin
            filt = filter_opposite(snap_q);
        end
    end

    assign rd_fall = rd_q & ~i_rd;
    assign rd_d    = i_rd;

    always_comb begin
        sh_d = sh_q;
        if (i_strobe) begin
            sh_d = filt;
        end else if (rd_fall) begin
            sh_d = {C_FILL_BIT, sh_q[BTN_W-1:1]};
        end
    end

    assign data_d = i_strobe ? filt[BTN_A] : sh_d[0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < C_SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            snap_q <= '0;
            sh_q   <= '0;
            rd_q   <= 1'b0;
            data_q <= 1'b0;
        end else begin
            for (int i = 0; i < C_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            snap_q <= snap_d;
            sh_q   <= sh_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule

// File: rtl/nes_joypad_serializer.sv
// Two independent NES controller ports ($4016/$4017) sharing the CPU strobe.
module nes_joypad_serializer
    import nes_joy_pkg::*;
#(
    parameter int C_SYNC_STAGES     = 2,
    parameter int C_FILTER_OPPOSITE = 1,
    parameter bit C_FILL_BIT        = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [BTN_W-1:0] i_btn0,
    input  logic [BTN_W-1:0] i_btn1,
    input  logic             i_strobe,
    input  logic             i_rd0,
    input  logic             i_rd1,
    output logic             o_data0,
    output logic             o_data1
);

    btn_vec_t btn  [2];
    logic     rd   [2];
    logic     data [2];

    assign btn[0] = i_btn0;
    assign btn[1] = i_btn1;
    assign rd[0]  = i_rd0;
    assign rd[1]  = i_rd1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            nes_joypad_port #(
                .C_SYNC_STAGES     (C_SYNC_STAGES),
                .C_FILTER_OPPOSITE (C_FILTER_OPPOSITE),
                .C_FILL_BIT        (C_FILL_BIT)
            ) u_port (
                .i_clk    (i_clk),
                .i_reset  (i_reset),
                .i_btn    (btn[gi]),
                .i_strobe (i_strobe),
                .i_rd     (rd[gi]),
                .o_data   (data[gi])
            );
        end
    endgenerate

    assign o_data0 = data[0];
    assign o_data1 = data[1];

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Randomised scoreboard bench: two DUTs (filter on / filter off) share stimulus,
// a button-level reference model predicts every serial bit.
module tb_nes_joypad_serializer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn0 = '0, btn1 = '0;
    logic       strobe = 1'b0, rd0 = 1'b0, rd1 = 1'b0;
    logic       d0_f, d1_f, d0_n, d1_n;

    nes_joypad_serializer #(.C_SYNC_STAGES(S), .C_FILTER_OPPOSITE(1), .C_FILL_BIT(1'b1)) dut_f (
        .i_clk(clk), .i_reset(rst), .i_btn0(btn0), .i_btn1(btn1), .i_strobe(strobe),
        .i_rd0(rd0), .i_rd1(rd1), .o_data0(d0_f), .o_data1(d1_f));

    nes_joypad_serializer #(.C_SYNC_STAGES(S), .C_FILTER_OPPOSITE(0), .C_FILL_BIT(1'b1)) dut_n (
        .i_clk(clk), .i_reset(rst), .i_btn0(btn0), .i_btn1(btn1), .i_strobe(strobe),
        .i_rd0(rd0), .i_rd1(rd1), .o_data0(d0_n), .o_data1(d1_n));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int    due;
        int    d;
        int    p;
        logic  exp;
        string name;
    } chk_t;
    chk_t chk_q[$];

    // Reference model: latched vector and number of reads per DUT/port.
    logic [7:0] vec [2][2];
    int         cnt [2][2];

    function automatic logic [7:0] model_filter(input int d, input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (d == 0) begin
            if (b[4] && b[5]) r = r & 8'hCF;
            if (b[6] && b[7]) r = r & 8'h3F;
        end
        return r;
    endfunction

    function automatic logic exp_bit(input int d, input int p);
        if (cnt[d][p] >= 8) return 1'b1;
        return vec[d][p][cnt[d][p]];
    endfunction

    function automatic logic actual(input int d, input int p);
        if (d == 0) return (p == 0) ? d0_f : d1_f;
        return (p == 0) ? d0_n : d1_n;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic push(input string name, input int d, input int p, input int due, input logic exp);
        chk_t c;
        c.due = due; c.d = d; c.p = p; c.exp = exp; c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic push_all(input string name, input int due);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                push($sformatf("%s_d%0d_p%0d", name, d, p), d, p, due, exp_bit(d, p));
    endtask

    // Monitor: consumes scheduled expectations at the sampling edge they refer to.
    always @(negedge clk) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].due == cyc) begin
                check(chk_q[i].name, actual(chk_q[i].d, chk_q[i].p), chk_q[i].exp);
                $display("txn %s cyc=%0d got=%b exp=%b", chk_q[i].name, cyc,
                         actual(chk_q[i].d, chk_q[i].p), chk_q[i].exp);
                chk_q.delete(i);
            end else if (chk_q[i].due < cyc) begin
                check({chk_q[i].name, "_missed"}, 1'b0, 1'b1);
                chk_q.delete(i);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                vec[d][p] = '0;
                cnt[d][p] = 0;
            end
        push_all("reset", cyc + 1);
        tick(2);
        rst = 1'b0;
        tick(S + 4);
    endtask

    task automatic set_btn(input logic [7:0] b0, input logic [7:0] b1);
        btn0 = b0;
        btn1 = b1;
        tick(S + 4);
    endtask

    task automatic do_strobe(input int n);
        strobe = 1'b1;
        tick(n);
        strobe = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vec[d][0] = model_filter(d, btn0);
            vec[d][1] = model_filter(d, btn1);
            cnt[d][0] = 0;
            cnt[d][1] = 0;
        end
        push_all("latch", cyc);
    endtask

    // mask bit0 = port 0, bit1 = port 1
    task automatic do_read(input int mask, input int hold, input int gap, input string name);
        rd0 = mask[0];
        rd1 = mask[1];
        tick(hold);
        rd0 = 1'b0;
        rd1 = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (mask[p] && cnt[d][p] < 8) cnt[d][p]++;
        push_all(name, cyc + 1);
        tick(1 + gap);
    endtask

    int run;
    logic [7:0] snap;
    logic [7:0] a_val;

    initial begin
        tick(1);
        do_reset();

        // Idle reads from reset: zeros until the fill bit reaches bit 0.
        for (int i = 0; i < 10; i++) do_read(1, 1, 1, "idle");

        // Directed latch, short and long reads.
        set_btn(8'b1000_0101, 8'h5A);
        do_strobe(3);
        for (int i = 0; i < 10; i++) do_read(1, 1, 1, "latch_short");
        do_strobe(3);
        for (int i = 0; i < 10; i++) do_read(1, 5, 2, "latch_long");

        // Opposite d-pad on port 1: filtered DUT reads 0 on bits 4/5, unfiltered reads 1.
        set_btn(8'h00, 8'b0011_0000);
        do_strobe(2);
        for (int i = 0; i < 9; i++) do_read(2, 1, 1, "opposite");
        set_btn(8'hC3, 8'hF0);
        do_strobe(1);
        for (int i = 0; i < 9; i++) do_read(3, 2, 1, "both_ports");

        // Strobe held: A followed live, reads ignored.
        a_val = 8'h26;
        set_btn(a_val, 8'h81);
        strobe = 1'b1;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            a_val[0] = ~a_val[0];
            btn0 = a_val;
            push("live_old_f", 0, 0, cyc + S + 1, ~a_val[0]);
            push("live_new_f", 0, 0, cyc + S + 2, a_val[0]);
            push("live_new_n", 1, 0, cyc + S + 2, a_val[0]);
            rd0 = 1'b1;
            tick(2);
            rd0 = 1'b0;
            tick(6);
        end
        strobe = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vec[d][0] = model_filter(d, btn0);
            vec[d][1] = model_filter(d, btn1);
            cnt[d][0] = 0;
            cnt[d][1] = 0;
        end
        push_all("live_release", cyc);
        for (int i = 0; i < 9; i++) do_read(1, 1, 1, "after_live");

        // Skewed arrival of 0x00 -> 0xFF: snapshot never sits on an intermediate value.
        set_btn(8'h00, 8'h00);
        run = 0;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: btn0 = 8'h03;
                1: btn0 = 8'h0F;
                2: btn0 = 8'h3F;
                3: btn0 = 8'hFF;
                default: ;
            endcase
            tick(1);
            @(negedge clk);
            snap = dut_n.g_port[0].u_port.snap_q;
            run = (snap != 8'h00 && snap != 8'hFF) ? run + 1 : 0;
            check("skew_intermediate", run > 1, 1'b0);
        end
        check("skew_settled", snap == 8'hFF, 1'b1);
        tick(1);
        do_strobe(2);
        for (int i = 0; i < 9; i++) do_read(1, 1, 1, "skew_read");

        // Reset mid-sequence then reads without strobe.
        do_read(1, 1, 0, "pre_reset");
        do_reset();
        for (int i = 0; i < 9; i++) do_read(3, 1, 0, "post_reset");

        // Randomised mix.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0: do_reset();
                1, 2: begin
                    set_btn(8'($urandom), 8'($urandom));
                    do_strobe($urandom_range(1, 4));
                end
                default: do_read($urandom_range(1, 3), $urandom_range(1, 4),
                                 $urandom_range(0, 2), "rand");
            endcase
        end

        for (int i = 0; i < 50 && chk_q.size() > 0; i++) tick(1);
        if (chk_q.size() > 0) check("scoreboard_drain", 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
